// File: rtl/output_bram_axis_tx.sv
// rtl/output_bram_axis_tx.sv - Streams a block of output BRAM words to an AXIS master
// through a credit-controlled FIFO that absorbs the fixed 2-cycle BRAM read latency.
module output_bram_axis_tx #(
    parameter int BRAM_DATA_WIDTH    = 32,
    parameter int BRAM_ADDRESS_WIDTH = 9,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          transfer_start,
    input  logic [11:0]                   output_channel_size,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_address_B,
    output logic                          bram_B_en,
    input  logic [BRAM_DATA_WIDTH-1:0]    data_from_bram_B,
    output logic [BRAM_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
    output logic                          send_finish
);
    localparam int CNT_W = 13;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** BRAM_ADDRESS_WIDTH);
    localparam logic [OCC_W-1:0] DEPTH     = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              size;
    logic [CNT_W-1:0]              issued;
    logic [CNT_W-1:0]              sent;
    logic [BRAM_ADDRESS_WIDTH-1:0] addr;
    logic                          rd_v1;
    logic                          rd_v2;
    logic [BRAM_DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [OCC_W-1:0]              occ;
    logic [OCC_W-1:0]              pending;
    logic                          issue;
    logic                          push;
    logic                          pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Reads still in the BRAM pipeline already own a FIFO slot, so credit counts them too.
    assign pending = occ + OCC_W'(rd_v1) + OCC_W'(rd_v2);
    assign issue   = (state == RUN) && (issued < size) && (pending < DEPTH);
    assign push    = rd_v2;
    assign pop     = (occ != '0) && m_axis_tready;

    assign bram_B_en      = issue;
    assign bram_address_B = addr;
    assign m_axis_tvalid  = (occ != '0);
    assign m_axis_tdata   = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign m_axis_tlast   = m_axis_tvalid && (sent == size - CNT_W'(1));
    assign busy           = (state != IDLE);
    assign send_finish    = (state == DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_from_bram_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            size   <= '0;
            issued <= '0;
            sent   <= '0;
            addr   <= '0;
            rd_v1  <= 1'b0;
            rd_v2  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_v1 <= issue;
            rd_v2 <= rd_v1;

            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push) begin
                occ <= occ - OCC_W'(1);
            end

            if (issue) begin
                addr   <= addr + BRAM_ADDRESS_WIDTH'(1);
                issued <= issued + CNT_W'(1);
            end
            if (pop) begin
                sent <= sent + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (transfer_start && (output_channel_size != 12'd0)) begin
                        state  <= RUN;
                        size   <= ({1'b0, output_channel_size} > MAX_WORDS) ?
                                  MAX_WORDS : {1'b0, output_channel_size};
                        addr   <= '0;
                        issued <= '0;
                        sent   <= '0;
                    end
                end
                RUN: begin
                    if (issue && (issued == size - CNT_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (sent == size - CNT_W'(1))) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
